// File: rtl/pio_gpio_ctrl.sv
// pio_gpio_ctrl: configurable Avalon-MM PIO slave.
// Inputs go through a synchroniser, an optional debouncer, start-up priming,
// edge capture and a maskable level interrupt. Outputs are driven by OUT_DATA
// with an optional per-bit hardware blink.
// Optional feature macro: PIO_GPIO_DEBOUNCE_EN (defined = per-bit debouncer
// present; undefined = debounced state follows the synchronised input).
module pio_gpio_ctrl #(
  parameter int          NUM_IN           = 4,
  parameter int          NUM_OUT          = 4,
  parameter int          DEBOUNCE_CYCLES  = 1000,
  parameter int          EDGE_MODE        = 2,
  parameter logic [31:0] BLINK_PERIOD_RST = 32'd50000000
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [2:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               irq,
  input  logic [NUM_IN-1:0]  pio_in,
  output logic [NUM_OUT-1:0] pio_out
);

  // Reject configurations outside the supported range at elaboration.
  if (NUM_IN < 1 || NUM_IN > 32 || NUM_OUT < 1 || NUM_OUT > 32 ||
      DEBOUNCE_CYCLES < 1 || EDGE_MODE < 0 || EDGE_MODE > 2) begin : gen_bad_param
    $error("pio_gpio_ctrl: parameter out of range");
  end

  logic [NUM_IN-1:0]  sync1_q, sync2_q;
  logic               arm_q, primed_q;
  logic               prime_load;
  logic [NUM_IN-1:0]  in_data;
  logic [NUM_IN-1:0]  in_dly_q;
  logic [NUM_IN-1:0]  edge_det;
  logic [NUM_IN-1:0]  irq_mask_q;
  logic [NUM_IN-1:0]  edge_cap_q, edge_cap_d;
  logic [NUM_OUT-1:0] out_data_q, blink_en_q, pio_out_q;
  logic [31:0]        blink_period_q, prescaler_q;
  logic               phase_q;
  logic [31:0]        rd_mux, readdata_q;
  logic               irq_q;

  logic wr_mask, wr_cap, wr_out, wr_blink, wr_period;
  assign wr_mask   = avs_write && (avs_address == 3'd1);
  assign wr_cap    = avs_write && (avs_address == 3'd2);
  assign wr_out    = avs_write && (avs_address == 3'd3);
  assign wr_blink  = avs_write && (avs_address == 3'd4);
  assign wr_period = avs_write && (avs_address == 3'd5);

  // Two-flop synchroniser; left unreset so it already tracks the pins when
  // reset releases, which is what priming relies on.
  always_ff @(posedge clk_clk) begin
    sync1_q <= pio_in;
    sync2_q <= sync1_q;
  end

  // Priming: arm on the first cycle after reset, load on the second.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      arm_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      arm_q <= 1'b1;
      if (arm_q) primed_q <= 1'b1;
    end
  end
  assign prime_load = arm_q && !primed_q;

`ifdef PIO_GPIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_IN-1:0] stable_q;
  logic [CW-1:0]     db_cnt_q [NUM_IN];

  // Per-bit debouncer: accept a change only after it has persisted.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stable_q <= '0;
      for (int i = 0; i < NUM_IN; i++) db_cnt_q[i] <= '0;
    end else if (prime_load) begin
      stable_q <= sync2_q;
      for (int i = 0; i < NUM_IN; i++) db_cnt_q[i] <= '0;
    end else if (primed_q) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end
  assign in_data = stable_q;
`else
  assign in_data = primed_q ? sync2_q : '0;
`endif

  // Delayed copy for edge detection; loaded together with priming so the
  // initial pin state never looks like an edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)     in_dly_q <= '0;
    else if (prime_load) in_dly_q <= sync2_q;
    else                 in_dly_q <= in_data;
  end

  // Edge filter and capture update; a new edge beats a same-cycle clear.
  always_comb begin
    edge_det = '0;
    case (EDGE_MODE)
      0:       edge_det = in_data & ~in_dly_q;
      1:       edge_det = ~in_data & in_dly_q;
      default: edge_det = in_data ^ in_dly_q;
    endcase
    edge_cap_d = edge_cap_q;
    if (wr_cap) edge_cap_d = edge_cap_q & ~avs_writedata[NUM_IN-1:0];
    edge_cap_d = edge_cap_d | edge_det;
  end

  // Control/status registers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      out_data_q <= '0;
      blink_en_q <= '0;
    end else begin
      edge_cap_q <= edge_cap_d;
      if (wr_mask)  irq_mask_q <= avs_writedata[NUM_IN-1:0];
      if (wr_out)   out_data_q <= avs_writedata[NUM_OUT-1:0];
      if (wr_blink) blink_en_q <= avs_writedata[NUM_OUT-1:0];
    end
  end

  // Blink prescaler and phase; a period write restarts the pattern low.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      blink_period_q <= BLINK_PERIOD_RST;
      prescaler_q    <= '0;
      phase_q        <= 1'b0;
    end else if (wr_period) begin
      blink_period_q <= (avs_writedata == 32'd0) ? 32'd1 : avs_writedata;
      prescaler_q    <= '0;
      phase_q        <= 1'b0;
    end else if (prescaler_q == blink_period_q - 32'd1) begin
      prescaler_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      prescaler_q <= prescaler_q + 32'd1;
    end
  end

  // Read mux; unused bits and addresses 6-7 read zero.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0: rd_mux[NUM_IN-1:0]  = in_data;
      3'd1: rd_mux[NUM_IN-1:0]  = irq_mask_q;
      3'd2: rd_mux[NUM_IN-1:0]  = edge_cap_q;
      3'd3: rd_mux[NUM_OUT-1:0] = out_data_q;
      3'd4: rd_mux[NUM_OUT-1:0] = blink_en_q;
      3'd5: rd_mux              = blink_period_q;
      default: rd_mux = '0;
    endcase
  end

  // Registered outputs: read data (held between reads), irq and pins.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
      pio_out_q  <= '0;
    end else begin
      if (avs_read) readdata_q <= rd_mux;
      irq_q     <= |(edge_cap_q & irq_mask_q);
      pio_out_q <= out_data_q & (~blink_en_q | {NUM_OUT{phase_q}});
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;
  assign pio_out      = pio_out_q;

endmodule

// File: tb/tb_pio_gpio_ctrl.sv
// Bench for pio_gpio_ctrl: three instances share one bus and one pin set,
// differing only in EDGE_MODE (instance g uses EDGE_MODE = g).
module tb_pio_gpio_ctrl;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int DB = 4;
  localparam logic [31:0] BP_RST = 32'd50000000;
`ifdef PIO_GPIO_DEBOUNCE_EN
  localparam int LAT  = 2 + DB;
  localparam int MINP = DB;
`else
  localparam int LAT  = 2;
`endif

  logic          clk;
  logic          rst;
  logic [2:0]    addr;
  logic          rd;
  logic          wr;
  logic [31:0]   wdata;
  logic [NI-1:0] pin;
  logic [31:0]   rdata [3];
  logic          irq_w [3];
  logic [NO-1:0] pout  [3];

  int checks;
  int failures;

  // behavioural model state
  logic [NI-1:0] m_in;
  logic [NI-1:0] m_cap [3];
  logic [NI-1:0] m_mask;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    pio_gpio_ctrl #(
      .NUM_IN(NI), .NUM_OUT(NO), .DEBOUNCE_CYCLES(DB),
      .EDGE_MODE(g), .BLINK_PERIOD_RST(BP_RST)
    ) u_dut (
      .clk_clk(clk), .reset_reset(rst), .avs_address(addr),
      .avs_read(rd), .avs_write(wr), .avs_writedata(wdata),
      .avs_readdata(rdata[g]), .irq(irq_w[g]), .pio_in(pin), .pio_out(pout[g])
    );
  end

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [NI-1:0] edges_for(input int mode, input logic [NI-1:0] o, input logic [NI-1:0] n);
    logic [NI-1:0] rise, fall;
    rise = n & ~o;
    fall = o & ~n;
    if (mode == 0) return rise;
    if (mode == 1) return fall;
    return rise | fall;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  // drive a new pin state, wait until every effect has settled, update model
  task automatic apply_input(input logic [NI-1:0] v);
    pin = v;
    repeat (LAT + 3) tick();
    for (int g = 0; g < 3; g++) m_cap[g] = m_cap[g] | edges_for(g, m_in, v);
    m_in = v;
  endtask

  task automatic test_reset();
    logic [31:0] exp_t [8];
    exp_t = '{32'hA, 32'h0, 32'h0, 32'h0, 32'h0, BP_RST, 32'h0, 32'h0};
    pin = 4'b1010;
    rst = 1'b1;
    repeat (4) tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (pout[g] !== 4'h0 || irq_w[g] !== 1'b0 || rdata[g] !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs g=%0d pout=%h irq=%b rdata=%h required 0", g, pout[g], irq_w[g], rdata[g]);
      end
    end
    rst = 1'b0;
    repeat (4) tick();
    m_in = 4'b1010; m_mask = '0;
    for (int g = 0; g < 3; g++) m_cap[g] = '0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a));
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (rdata[g] !== exp_t[a]) begin
          failures++;
          $display("FAIL reset_reg a=%0d g=%0d got=%h required=%h", a, g, rdata[g], exp_t[a]);
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (irq_w[g] !== 1'b0 || pout[g] !== 4'h0) begin
        failures++;
        $display("FAIL reset_primed g=%0d irq=%b pout=%h required 0", g, irq_w[g], pout[g]);
      end
    end
  endtask

`ifdef PIO_GPIO_DEBOUNCE_EN
  task automatic test_glitch();
    for (int t = 0; t < 4; t++) begin
      int len, b;
      len = $urandom_range(1, MINP - 1);
      b   = $urandom_range(0, NI - 1);
      pin = m_in ^ NI'(1 << b);
      repeat (len) tick();
      pin = m_in;
      repeat (LAT + 3) tick();
      bus_read(3'd0);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (rdata[g][NI-1:0] !== m_in) begin
          failures++;
          $display("FAIL glitch_in len=%0d g=%0d got=%h required=%h", len, g, rdata[g], m_in);
        end
      end
      bus_read(3'd2);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (rdata[g][NI-1:0] !== m_cap[g]) begin
          failures++;
          $display("FAIL glitch_cap len=%0d g=%0d got=%h required=%h", len, g, rdata[g], m_cap[g]);
        end
      end
    end
  endtask
`endif

  task automatic test_hold_latency();
    logic e;
    logic [NI-1:0] nv;
    bus_write(3'd1, 32'h1);
    m_mask = 4'h1;
    nv = m_in | 4'h1;
    addr = 3'd0; rd = 1'b1;
    pin = nv;
    for (int n = 1; n <= LAT + 3; n++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        e = (n - 1 >= LAT);
        checks++;
        if (rdata[g][0] !== e) begin
          failures++;
          $display("FAIL latency_in n=%0d g=%0d got=%b required=%b", n, g, rdata[g][0], e);
        end
        e = (n >= LAT + 2) && (g != 1);
        checks++;
        if (irq_w[g] !== e) begin
          failures++;
          $display("FAIL latency_irq n=%0d g=%0d got=%b required=%b", n, g, irq_w[g], e);
        end
      end
    end
    rd = 1'b0;
    for (int g = 0; g < 3; g++) m_cap[g] = m_cap[g] | edges_for(g, m_in, nv);
    m_in = nv;
    bus_read(3'd2);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rdata[g][NI-1:0] !== m_cap[g]) begin
        failures++;
        $display("FAIL latency_cap g=%0d got=%h required=%h", g, rdata[g], m_cap[g]);
      end
    end
  endtask

  task automatic test_irq_clear();
    logic [NI-1:0] nv;
    logic e;
    bus_write(3'd2, 32'h1);
    for (int g = 0; g < 3; g++) begin
      e = (g != 1);
      checks++;
      if (irq_w[g] !== e) begin
        failures++;
        $display("FAIL clear_irq_hold g=%0d got=%b required=%b", g, irq_w[g], e);
      end
      m_cap[g] = m_cap[g] & ~4'h1;
    end
    tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (irq_w[g] !== 1'b0) begin
        failures++;
        $display("FAIL clear_irq_low g=%0d got=%b required=0", g, irq_w[g]);
      end
    end
    // falling edge on bit 0 whose capture lands on the clear edge
    nv = m_in & ~4'h1;
    pin = nv;
    repeat (LAT) tick();
    bus_write(3'd2, 32'h1);
    for (int g = 0; g < 3; g++) m_cap[g] = (m_cap[g] & ~4'h1) | edges_for(g, m_in, nv);
    m_in = nv;
    tick(); tick();
    bus_read(3'd2);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rdata[g][NI-1:0] !== m_cap[g]) begin
        failures++;
        $display("FAIL set_wins_cap g=%0d got=%h required=%h", g, rdata[g], m_cap[g]);
      end
      e = |(m_cap[g] & m_mask);
      checks++;
      if (irq_w[g] !== e) begin
        failures++;
        $display("FAIL set_wins_irq g=%0d got=%b required=%b", g, irq_w[g], e);
      end
    end
    bus_write(3'd2, 32'hF);
    for (int g = 0; g < 3; g++) m_cap[g] = '0;
    tick(); tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (irq_w[g] !== 1'b0) begin
        failures++;
        $display("FAIL clear_all_irq g=%0d got=%b required=0", g, irq_w[g]);
      end
    end
  endtask

  task automatic test_edge_mode();
    apply_input(m_in | 4'h4);
    bus_write(3'd2, 32'hF);
    for (int g = 0; g < 3; g++) m_cap[g] = '0;
    apply_input(m_in & ~4'h4);
    bus_read(3'd2);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rdata[g][NI-1:0] !== m_cap[g]) begin
        failures++;
        $display("FAIL edge_mode_fall g=%0d got=%h required=%h", g, rdata[g], m_cap[g]);
      end
    end
    bus_read(3'd0);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rdata[g][NI-1:0] !== m_in) begin
        failures++;
        $display("FAIL edge_mode_in g=%0d got=%h required=%h", g, rdata[g], m_in);
      end
    end
  endtask

  task automatic test_random();
    logic [NI-1:0] c;
    logic e;
    m_mask = NI'($urandom_range(1, 15));
    bus_write(3'd1, {28'h0, m_mask});
    for (int it = 0; it < 12; it++) begin
      apply_input(NI'($urandom_range(0, 15)));
      c = NI'($urandom_range(0, 15));
      bus_write(3'd2, {28'h0, c});
      for (int g = 0; g < 3; g++) m_cap[g] = m_cap[g] & ~c;
      bus_read(3'd0);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (rdata[g][NI-1:0] !== m_in) begin
          failures++;
          $display("FAIL rand_in it=%0d g=%0d got=%h required=%h", it, g, rdata[g], m_in);
        end
      end
      bus_read(3'd2);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (rdata[g][NI-1:0] !== m_cap[g]) begin
          failures++;
          $display("FAIL rand_cap it=%0d g=%0d got=%h required=%h", it, g, rdata[g], m_cap[g]);
        end
        e = |(m_cap[g] & m_mask);
        checks++;
        if (irq_w[g] !== e) begin
          failures++;
          $display("FAIL rand_irq it=%0d g=%0d got=%b required=%b", it, g, irq_w[g], e);
        end
      end
    end
  endtask

  task automatic test_registers();
    logic [31:0] exp_t [8];
    bus_write(3'd6, 32'hFFFFFFFF);
    bus_write(3'd7, 32'hFFFFFFFF);
    bus_write(3'd0, 32'hFFFFFFFF);
    bus_write(3'd1, 32'hFFFFFFFF);
    m_mask = 4'hF;
    bus_write(3'd3, 32'hFFFFFFFF);
    bus_write(3'd4, 32'hFFFFFFFF);
    exp_t = '{{28'h0, m_in}, 32'hF, {28'h0, m_cap[0]}, 32'hF, 32'hF, BP_RST, 32'h0, 32'h0};
    for (int a = 0; a < 8; a++) begin
      if (a == 2) continue;
      bus_read(3'(a));
      checks++;
      if (rdata[0] !== exp_t[a]) begin
        failures++;
        $display("FAIL reg_rw a=%0d got=%h required=%h", a, rdata[0], exp_t[a]);
      end
    end
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h0);
    bus_read(3'd5);
    checks++;
    if (rdata[0] !== 32'h1) begin
      failures++;
      $display("FAIL period_zero got=%h required=00000001", rdata[0]);
    end
    // simultaneous read and write returns the pre-write value
    bus_write(3'd3, 32'h3);
    addr = 3'd3; rd = 1'b1; wr = 1'b1; wdata = 32'hC;
    tick();
    rd = 1'b0; wr = 1'b0;
    checks++;
    if (rdata[0] !== 32'h3) begin
      failures++;
      $display("FAIL rw_same_cycle got=%h required=00000003", rdata[0]);
    end
    tick();
    checks++;
    if (rdata[0] !== 32'h3) begin
      failures++;
      $display("FAIL readdata_hold got=%h required=00000003", rdata[0]);
    end
    bus_read(3'd3);
    checks++;
    if (rdata[0] !== 32'hC) begin
      failures++;
      $display("FAIL rw_after got=%h required=0000000c", rdata[0]);
    end
  endtask

  task automatic test_out_latency();
    tick();
    bus_write(3'd3, 32'h5);
    checks++;
    if (pout[0] !== 4'hC) begin
      failures++;
      $display("FAIL out_latency_old got=%h required=c", pout[0]);
    end
    tick();
    checks++;
    if (pout[0] !== 4'h5) begin
      failures++;
      $display("FAIL out_latency_new got=%h required=5", pout[0]);
    end
  endtask

  task automatic test_blink();
    logic [NO-1:0] e;
    int p, eff, ph;
    bus_write(3'd3, 32'hF);
    bus_write(3'd4, 32'h3);
    for (int run = 0; run < 3; run++) begin
      p = (run == 0) ? 5 : (run == 1) ? 0 : $urandom_range(2, 7);
      eff = (p == 0) ? 1 : p;
      bus_write(3'd5, 32'(p));
      for (int n = 1; n <= 4 * eff + 2; n++) begin
        tick();
        ph = ((n - 1) / eff) % 2;
        e = 4'b1100 | ((ph != 0) ? 4'b0011 : 4'b0000);
        for (int g = 0; g < 3; g++) begin
          checks++;
          if (pout[g] !== e) begin
            failures++;
            $display("FAIL blink p=%0d n=%0d g=%0d got=%h required=%h", p, n, g, pout[g], e);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NI-1:0] v;
    apply_input(m_in ^ 4'hF);
    bus_read(3'd0);
    v = NI'($urandom_range(0, 15));
    pin = v;
    rst = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rdata[g] !== 32'h0 || irq_w[g] !== 1'b0 || pout[g] !== 4'h0) begin
        failures++;
        $display("FAIL midreset_out g=%0d rdata=%h irq=%b pout=%h required 0", g, rdata[g], irq_w[g], pout[g]);
      end
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    m_in = v;
    for (int g = 0; g < 3; g++) m_cap[g] = '0;
    bus_read(3'd0);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rdata[g][NI-1:0] !== v) begin
        failures++;
        $display("FAIL midreset_in g=%0d got=%h required=%h", g, rdata[g], v);
      end
    end
    bus_read(3'd2);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rdata[g] !== 32'h0) begin
        failures++;
        $display("FAIL midreset_cap g=%0d got=%h required=0", g, rdata[g]);
      end
    end
    bus_read(3'd5);
    checks++;
    if (rdata[0] !== BP_RST) begin
      failures++;
      $display("FAIL midreset_period got=%h required=%h", rdata[0], BP_RST);
    end
    bus_read(3'd3);
    checks++;
    if (rdata[0] !== 32'h0 || pout[0] !== 4'h0) begin
      failures++;
      $display("FAIL midreset_out_data rdata=%h pout=%h required 0", rdata[0], pout[0]);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0; pin = '0;
    m_in = '0; m_mask = '0;
    for (int g = 0; g < 3; g++) m_cap[g] = '0;
    test_reset();
`ifdef PIO_GPIO_DEBOUNCE_EN
    test_glitch();
`endif
    test_hold_latency();
    test_irq_clear();
    test_edge_mode();
    test_random();
    test_registers();
    test_out_latency();
    test_blink();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
